// File: rtl/countdown_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_pkg
// Description : Shared state encoding and digit geometry for the loadable
//               down-counting timer and its 4-bit digit slices.
// Revision    : 1.0 - initial release
// ============================================================================
package countdown_timer_pkg;

    // Width of one counting digit; the timer count is built from these.
    localparam int unsigned DIGIT_W = 4;

    // Timer control states, 2-bit encoding shared with the display/game logic.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    // Number of digits needed to cover a count of the given width.
    function automatic int unsigned num_digits(input int unsigned width);
        return width / DIGIT_W;
    endfunction

endpackage : countdown_timer_pkg
`default_nettype wire

// File: rtl/count4_down.sv
`default_nettype none
// ============================================================================
// Module      : count4_down
// Description : One 4-bit binary down-counting digit with synchronous reset,
//               parallel load and a borrow-terminal-count output used to
//               ripple the decrement into the next more significant digit.
// Revision    : 1.0 - initial release
// ============================================================================
module count4_down
    import countdown_timer_pkg::*;
(
    input  logic               clk,
    input  logic               R,
    input  logic               Ld,
    input  logic [DIGIT_W-1:0] Din,
    input  logic               Dw,
    output logic [DIGIT_W-1:0] Q,
    output logic               BTC
);

    // Reset clears, load presets, otherwise a decrement request steps down.
    always_ff @(posedge clk) begin
        if (R) begin
            Q <= '0;
        end else if (Ld) begin
            Q <= Din;
        end else if (Dw) begin
            Q <= Q - DIGIT_W'(1);
        end
    end

    // This digit wraps 0 -> F on this decrement, so the next digit must borrow.
    assign BTC = (Q == '0) && Dw;

endmodule : count4_down
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Loadable down-counting timer. A preset is loaded, Start runs
//               the count down by one per Dec tick, Stop pauses it, and on
//               reaching zero the timer returns to IDLE with a one-cycle Done
//               pulse. Count is held in a chain of 4-bit digits.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             R,
    input  logic             Ld,
    input  logic [WIDTH-1:0] Din,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Dec,
    output logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Zero,
    output logic             Done
);

    localparam int unsigned NDIG = num_digits(WIDTH);

    state_t            r_state;
    logic              w_dec_en;
    logic              w_q_is_one;
    logic [NDIG-1:0]   w_dw;
    logic [NDIG-1:0]   w_btc;

    // A tick counts only while running and not overridden by a load or a stop
    // on the same edge (the stop wins and the tick is dropped).
    assign w_dec_en   = Dec && (r_state == ST_RUN) && !Ld && !Stop;
    assign w_q_is_one = (Q == WIDTH'(1));

    // Digit chain: digit 0 sees the qualified tick, each higher digit borrows
    // only when every lower digit wraps on this tick.
    generate
        for (genvar k = 0; k < NDIG; k++) begin : g_digit
            if (k == 0) begin : g_lsd
                assign w_dw[k] = w_dec_en;
            end else begin : g_upper
                assign w_dw[k] = w_btc[k-1];
            end

            count4_down u_digit (
                .clk (clk),
                .R   (R),
                .Ld  (Ld),
                .Din (Din[k*DIGIT_W +: DIGIT_W]),
                .Dw  (w_dw[k]),
                .Q   (Q[k*DIGIT_W +: DIGIT_W]),
                .BTC (w_btc[k])
            );
        end
    endgenerate

    // Control FSM and Done register; priority R > Ld > Stop > Start > Dec.
    always_ff @(posedge clk) begin
        if (R) begin
            r_state <= ST_IDLE;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Ld) begin
                // Loading aborts any run silently.
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // Starting an empty timer is meaningless; stay idle.
                        if (Start && (Q != '0)) begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (Stop) begin
                            r_state <= ST_PAUSE;
                        end else if (w_dec_en && w_q_is_one) begin
                            r_state <= ST_IDLE;
                            Done    <= 1'b1;
                        end else if (w_btc[NDIG-1]) begin
                            // A borrow out of the top digit cannot occur since
                            // the run ends at 1 -> 0; never keep running on wrap.
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_PAUSE: begin
                        if (!Stop && Start) begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Status decodes of registered state only.
    assign Busy = (r_state == ST_RUN);
    assign Zero = (Q == '0);

endmodule : countdown_timer
`default_nettype wire

// File: doc/countdown_timer.md
# countdown_timer

Loadable 8-bit down-counting timer: the count-down counterpart of the up-counting time counter. It takes a preset from switches or control logic and decrements once per qualified `Dec` tick. On reaching zero it stops and emits a one-cycle `Done` pulse. It sits beside the elapsed-time counter in the timer/game datapath and drives the same display path through `Q`.

## Interface
- `WIDTH`, 8: count width; must be a multiple of 4, built from 4-bit digits.
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `R`, input, 1: reset, synchronous, active-high.
- `Ld`, input, 1: load `Din` into the count.
- `Din`, input, WIDTH: preset value, binary.
- `Start`, input, 1: start from IDLE, or resume from PAUSE.
- `Stop`, input, 1: pause while running.
- `Dec`, input, 1: decrement strobe, typically a 1 Hz one-cycle tick; counted only in RUN.
- `Q`, output, WIDTH: current count, registered.
- `Busy`, output, 1: high while state is RUN.
- `Zero`, output, 1: high when `Q == 0`.
- `Done`, output, 1: one-cycle pulse when the count reaches 0 in RUN.

## Operation
- **States:** IDLE, RUN, PAUSE; encoded in 2 bits.
- **Reset:** `R` high at an edge gives state=IDLE, `Q`=0, `Done`=0. `Busy`=0 and `Zero`=1 follow. `R` has priority over every other input, including mid-run.
- **Input priority per edge:** `R` > `Ld` > `Stop` > `Start` > `Dec`.
- **`Ld`, any state:** `Q`<=`Din`, state<=IDLE, `Done`<=0. A load during RUN aborts the run without a `Done` pulse.
- **IDLE:**
  - `Start` with `Q`!=0 → RUN.
  - `Start` with `Q`==0 is ignored: stay in IDLE, no `Done`.
  - `Dec` is ignored.
- **RUN:**
  - `Dec` → `Q`<=`Q`-1.
  - If `Q`==1 and `Dec`: `Q`<=0, `Done`<=1, state<=IDLE.
  - `Stop` → PAUSE; a `Dec` in the same cycle is dropped.
- **PAUSE:**
  - `Q` holds; `Dec` is ignored.
  - `Start` → RUN.
  - `Stop` → stays in PAUSE.
- **Arithmetic:**
  - Plain binary decrement, built as a chain of 4-bit digits. Each digit borrows from the next only when its own value is 0 and it receives a decrement.
  - Example: 0x10 → 0x0F.
  - `Q` never wraps below 0, because RUN is always left on reaching 0.
- **`Done`:** registered; high for exactly one cycle, then cleared at the next edge unless re-asserted (which is impossible by construction).

## Timing
- Inputs are sampled at the rising edge; `Q`, state and `Done` update at that same edge.
- Decrement latency: `Dec` high at edge N → new `Q` visible after edge N.
- `Done` rises at the same edge where `Q` becomes 0. At that edge `Busy` falls and `Zero` rises.
- `Start` at edge N → `Busy` high after edge N. The first `Dec` that counts must be sampled at edge N+1 or later; a `Dec` coincident with `Start` in IDLE is not counted.
- `Busy` and `Zero` are combinational decodes of registers; there are no combinational paths from inputs to outputs.

## Structure
- **Shared package:** state encoding constants (`ST_IDLE`=2'b00, `ST_RUN`=2'b01, `ST_PAUSE`=2'b10) and the digit width constant 4.
- **Sub-module `count4_down`:** one 4-bit digit with `clk`, `R`, `Ld`, `Din[3:0]`, `Dw`, `Q[3:0]`, `BTC` (borrow terminal count = `Q`==0 & `Dw`).
- **Chaining:** digit k's `Dw` = `Dec` & RUN & the AND of all lower digits' `BTC`; instantiate WIDTH/4 digits.
- **Top level:** FSM, priority logic, `Done` register and the output decodes.

## Test plan
- **Reset:** run to `Q`=0x25, assert `R` for 1 cycle → `Q`=0x00, `Busy`=0, `Zero`=1, `Done`=0 the next cycle.
- **Count to zero:**
  - Stimulus: `Ld` `Din`=0x03, `Start`, then 3 `Dec` pulses.
  - Required: `Q` steps 0x02, 0x01, 0x00.
  - Required: `Done` high for exactly the cycle after the 3rd `Dec`; `Busy` low from then on.
  - Required: further `Dec` pulses leave `Q` at 0x00.
- **Borrow:** `Ld` 0x10, `Start`, 1 `Dec` → `Q`=0x0F. Also `Ld` 0x00 then `Start` → state stays IDLE, no `Done`.
- **Pause:**
  - Stimulus: `Ld` 0x05, `Start`, 2 `Dec` → `Q`=0x03.
  - Stimulus: `Stop`, then 4 `Dec` → `Q`=0x03, `Busy`=0.
  - Stimulus: `Start`, then 3 `Dec` → `Q`=0x00 with one `Done` pulse.
- **Simultaneous events:**
  - `Stop`+`Dec` at `Q`=0x04 → `Q`=0x04, PAUSE.
  - `Ld` 0x09 + `Dec` in RUN → `Q`=0x09, IDLE.
  - `R`+`Ld` → `Q`=0x00.
- **Abort:** running at `Q`=0x01, `Ld` 0x07 coincident with `Dec` → `Q`=0x07, IDLE, `Done` never asserted.
